mips_alu: RTL and testbench

- Execute-stage arithmetic/logic unit of the 5-stage MIPS32 pipeline.
- Consumes the decoded ALU bundle registered in the DEC→EX pipeline register (alu_input_ifc). Produces the result and branch outcome (alu_output_ifc) in the same cycle, for EX glue, forwarding and branch resolution.
- Also drives the pass/done test-completion flags (pass_done_ifc) from the MTC0 pseudo-operations.

---
 rtl/mips_alu.sv | 113 +++++++++++
 tb/tb_mips_alu.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_alu.sv
// Execute-stage ALU for the 5-stage MIPS32 pipeline: zero-latency result and branch outcome,
// plus sticky pass/done test-completion flags driven by MTC0 pseudo-operations.
module mips_alu #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [4:0]            in_alu_ctl,
  input  logic [DATA_WIDTH-1:0] in_op1,
  input  logic [DATA_WIDTH-1:0] in_op2,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_branch_outcome,
  output logic                  done,
  output logic                  pass
);

  localparam logic [4:0] AluNop      = 5'd0;
  localparam logic [4:0] AluAdd      = 5'd1;
  localparam logic [4:0] AluAddu     = 5'd2;
  localparam logic [4:0] AluSub      = 5'd3;
  localparam logic [4:0] AluSubu     = 5'd4;
  localparam logic [4:0] AluAnd      = 5'd5;
  localparam logic [4:0] AluOr       = 5'd6;
  localparam logic [4:0] AluXor      = 5'd7;
  localparam logic [4:0] AluNor      = 5'd8;
  localparam logic [4:0] AluSlt      = 5'd9;
  localparam logic [4:0] AluSltu     = 5'd10;
  localparam logic [4:0] AluSll      = 5'd11;
  localparam logic [4:0] AluSrl      = 5'd12;
  localparam logic [4:0] AluSra      = 5'd13;
  localparam logic [4:0] AluLui      = 5'd14;
  localparam logic [4:0] AluBa       = 5'd15;
  localparam logic [4:0] AluBeq      = 5'd16;
  localparam logic [4:0] AluBne      = 5'd17;
  localparam logic [4:0] AluBlez     = 5'd18;
  localparam logic [4:0] AluBgtz     = 5'd19;
  localparam logic [4:0] AluBgez     = 5'd20;
  localparam logic [4:0] AluBltz     = 5'd21;
  localparam logic [4:0] AluMtc0Pass = 5'd22;
  localparam logic [4:0] AluMtc0Fail = 5'd23;
  localparam logic [4:0] AluMtc0Done = 5'd24;

  logic [4:0] shamt;
  logic       op1_neg;
  logic       op1_zero;
  logic       done_q, done_d;
  logic       pass_q, pass_d;

  assign shamt    = in_op2[4:0];
  assign op1_neg  = in_op1[DATA_WIDTH-1];
  assign op1_zero = (in_op1 == '0);

  assign out_valid = in_valid;

  always_comb begin
    out_result         = '0;
    out_branch_outcome = 1'b0;
    case (in_alu_ctl)
      AluAdd, AluAddu: out_result = in_op1 + in_op2;
      AluSub, AluSubu: out_result = in_op1 - in_op2;
      AluAnd:          out_result = in_op1 & in_op2;
      AluOr:           out_result = in_op1 | in_op2;
      AluXor:          out_result = in_op1 ^ in_op2;
      AluNor:          out_result = ~(in_op1 | in_op2);
      AluSlt:
        out_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(in_op1) < $signed(in_op2))};
      AluSltu:         out_result = {{(DATA_WIDTH-1){1'b0}}, (in_op1 < in_op2)};
      AluSll:          out_result = in_op1 << shamt;
      AluSrl:          out_result = in_op1 >> shamt;
      AluSra:          out_result = $signed(in_op1) >>> shamt;
      AluLui:          out_result = {in_op2[15:0], 16'h0000};
      AluBa:           out_branch_outcome = 1'b1;
      AluBeq:          out_branch_outcome = (in_op1 == in_op2);
      AluBne:          out_branch_outcome = (in_op1 != in_op2);
      AluBlez:         out_branch_outcome = op1_neg | op1_zero;
      AluBgtz:         out_branch_outcome = ~op1_neg & ~op1_zero;
      AluBgez:         out_branch_outcome = ~op1_neg;
      AluBltz:         out_branch_outcome = op1_neg;
      // NOP, MTC0 pseudo-ops and unused codes all produce zero outputs.
      default: ;
    endcase
  end

  // Flags freeze once done is set, so a later MTC0_FAIL cannot clobber a reported pass.
  always_comb begin
    done_d = done_q;
    pass_d = pass_q;
    if (in_valid && !done_q) begin
      case (in_alu_ctl)
        AluMtc0Pass: pass_d = 1'b1;
        AluMtc0Fail: pass_d = 1'b0;
        AluMtc0Done: done_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end

  assign done = done_q;
  assign pass = pass_q;

endmodule

// File: tb/tb_mips_alu.sv
// Scoreboard bench for mips_alu: directed corner vectors plus randomized traffic checked
// against an arithmetic reference model.
module tb_mips_alu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [4:0]  in_alu_ctl;
  logic [31:0] in_op1;
  logic [31:0] in_op2;
  logic        out_valid;
  logic [31:0] out_result;
  logic        out_branch_outcome;
  logic        done;
  logic        pass;

  typedef struct {
    logic        valid;
    logic [31:0] result;
    logic        br;
    logic        done;
    logic        pass;
    logic [4:0]  ctl;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;
  logic m_done;
  logic m_pass;

  mips_alu #(.DATA_WIDTH(32)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_valid           (in_valid),
    .in_alu_ctl         (in_alu_ctl),
    .in_op1             (in_op1),
    .in_op2             (in_op2),
    .out_valid          (out_valid),
    .out_result         (out_result),
    .out_branch_outcome (out_branch_outcome),
    .done               (done),
    .pass               (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: operands viewed as mathematical integers, shifts as multiply/divide by 2^s.
  function automatic void ref_alu(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic br);
    longint ua, ub, sa, sb, p;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = longint'(1) << (ub % 32);
    r  = 32'd0;
    br = 1'b0;
    case (c)
      5'd1, 5'd2: r = 32'(ua + ub);
      5'd3, 5'd4: r = 32'(ua - ub);
      5'd5:  r = a & b;
      5'd6:  r = a | b;
      5'd7:  r = a ^ b;
      5'd8:  r = ~(a | b);
      5'd9:  r = (sa < sb) ? 32'd1 : 32'd0;
      5'd10: r = (ua < ub) ? 32'd1 : 32'd0;
      5'd11: r = 32'(ua * p);
      5'd12: r = 32'(ua / p);
      5'd13: r = (sa >= 0) ? 32'(sa / p) : 32'(-(((-sa) + p - 1) / p));
      5'd14: r = 32'((ub % 65536) * 65536);
      5'd15: br = 1'b1;
      5'd16: br = (ua == ub);
      5'd17: br = (ua != ub);
      5'd18: br = (sa <= 0);
      5'd19: br = (sa > 0);
      5'd20: br = (sa >= 0);
      5'd21: br = (sa < 0);
      default: ;
    endcase
  endfunction

  // Clock the flag model with the inputs that were present across the edge.
  task automatic model_edge();
    if (rst_n && in_valid && !m_done) begin
      case (in_alu_ctl)
        5'd22: m_pass = 1'b1;
        5'd23: m_pass = 1'b0;
        5'd24: m_done = 1'b1;
        default: ;
      endcase
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.valid = in_valid;
    ref_alu(in_alu_ctl, in_op1, in_op2, e.result, e.br);
    e.done = m_done;
    e.pass = m_pass;
    e.ctl  = in_alu_ctl;
    exp_q.push_back(e);
  endtask

  task automatic apply(input logic v, input logic [4:0] c, input logic [31:0] a,
                       input logic [31:0] b);
    @(posedge clk);
    model_edge();
    #1;
    in_valid   = v;
    in_alu_ctl = c;
    in_op1     = a;
    in_op2     = b;
    push_exp();
  endtask

  // Drop reset between edges, so the flags must clear with no clock.
  task automatic apply_mid_reset(input logic v, input logic [4:0] c, input logic [31:0] a,
                                 input logic [31:0] b);
    @(posedge clk);
    model_edge();
    #1;
    in_valid   = v;
    in_alu_ctl = c;
    in_op1     = a;
    in_op2     = b;
    #1;
    rst_n  = 1'b0;
    m_done = 1'b0;
    m_pass = 1'b0;
    push_exp();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic random_burst(input int n);
    logic        v;
    logic [4:0]  c;
    logic [31:0] a, b;
    for (int i = 0; i < n; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = 5'($urandom_range(0, 31));
      if (c >= 5'd22 && c <= 5'd24 && $urandom_range(0, 3) != 0) c = 5'($urandom_range(0, 21));
      case ($urandom_range(0, 4))
        0: a = 32'h0000_0000;
        1: a = 32'h8000_0000;
        2: a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      apply(v, c, a, b);
    end
  endtask

  // Monitor: the DUT presents a response every cycle; compare it mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (out_valid !== e.valid) begin
          miscompares++;
          $display("FAIL valid ctl=%0d got %b want %b", e.ctl, out_valid, e.valid);
        end
        if (out_result !== e.result) begin
          miscompares++;
          $display("FAIL result ctl=%0d got %h want %h", e.ctl, out_result, e.result);
        end
        if (out_branch_outcome !== e.br) begin
          miscompares++;
          $display("FAIL branch ctl=%0d got %b want %b", e.ctl, out_branch_outcome, e.br);
        end
        if (done !== e.done) begin
          miscompares++;
          $display("FAIL done ctl=%0d got %b want %b", e.ctl, done, e.done);
        end
        if (pass !== e.pass) begin
          miscompares++;
          $display("FAIL pass ctl=%0d got %b want %b", e.ctl, pass, e.pass);
        end
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_done      = 1'b0;
    m_pass      = 1'b0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_alu_ctl  = 5'd0;
    in_op1      = 32'd0;
    in_op2      = 32'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    apply(1'b0, 5'd0,  32'h0000_0000, 32'h0000_0000);
    apply(1'b0, 5'd24, 32'h0000_0000, 32'h0000_0000);
    apply(1'b1, 5'd2,  32'hFFFF_FFFF, 32'h0000_0001);
    apply(1'b1, 5'd3,  32'h0000_0000, 32'h0000_0001);
    apply(1'b1, 5'd9,  32'hFFFF_FFFF, 32'h0000_0001);
    apply(1'b1, 5'd10, 32'hFFFF_FFFF, 32'h0000_0001);
    apply(1'b1, 5'd8,  32'h0000_0000, 32'h0000_0000);
    for (int s = 11; s <= 13; s++) begin
      apply(1'b1, 5'(s), 32'h8000_0001, 32'h0000_0004);
      apply(1'b1, 5'(s), 32'h8000_0001, 32'h0000_0024);
    end
    apply(1'b1, 5'd14, 32'h0000_0000, 32'h0000_1234);
    for (int c = 15; c <= 21; c++) begin
      apply(1'b1, 5'(c), 32'h0000_0000, 32'h0000_0000);
      apply(1'b1, 5'(c), 32'h8000_0000, 32'h0000_0000);
    end
    apply(1'b1, 5'd1,  32'h0000_0000, 32'h0000_0000);
    for (int c = 25; c <= 31; c++) apply(1'b1, 5'(c), 32'hDEAD_BEEF, 32'h1234_5678);
    apply(1'b1, 5'd22, 32'h0, 32'h0);
    apply(1'b1, 5'd0,  32'h0, 32'h0);
    apply(1'b1, 5'd24, 32'h0, 32'h0);
    apply(1'b1, 5'd23, 32'h0, 32'h0);
    apply(1'b1, 5'd0,  32'h0, 32'h0);
    apply(1'b1, 5'd0,  32'h0, 32'h0);
    apply_mid_reset(1'b1, 5'd7, 32'h0F0F_0F0F, 32'hFF00_FF00);
    apply(1'b0, 5'd0, 32'h0, 32'h0);

    random_burst(400);
    apply_mid_reset(1'b1, 5'd2, 32'h1234_5678, 32'h1111_1111);
    random_burst(400);
    apply(1'b0, 5'd0, 32'h0, 32'h0);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
